// File: rtl/lru_arb_pkg.sv
// Shared types and constants for the LRU matrix arbiter.
// The FSM state enum, the hold-counter width and the upper-triangle index
// helper are used by both the top level and the priority-matrix sub-module.
package lru_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Width of the tenure counter (wide enough for the largest MAX_HOLD).
  localparam int CNT_W = 16;

  // Flat index of pair (i, j), i < j, in the packed upper triangle of an
  // n x n matrix.
  function automatic int tri_idx(input int n, input int i, input int j);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/lru_matrix_arbiter_if.sv
// Request/grant bundle between the requestors (master) and the arbiter (slave).
interface lru_matrix_arbiter_if #(
  parameter int NUM_REQUESTORS = 4
);
  localparam int ID_W = $clog2(NUM_REQUESTORS);

  logic [NUM_REQUESTORS-1:0] req;
  logic [NUM_REQUESTORS-1:0] last;
  logic [NUM_REQUESTORS-1:0] grant;
  logic                      grant_valid;
  logic [ID_W-1:0]           grant_id;

  modport master (
    output req, last,
    input  grant, grant_valid, grant_id
  );

  modport slave (
    input  req, last,
    output grant, grant_valid, grant_id
  );
endinterface

// File: rtl/lru_matrix_prio.sv
// Priority matrix: stores only the upper triangle (bit set = lower index
// beats higher index), picks the unique requestor that beats every other
// requestor, and demotes the granted requestor below everyone on update.
module lru_matrix_prio
  import lru_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         upd,
  input  logic [N-1:0] upd_onehot,
  output logic [N-1:0] winner
);

  localparam int NP = N * (N - 1) / 2;

  logic [NP-1:0] p_q;

  // Matrix storage: reset gives index 0 top priority; a grant clears row k
  // and sets column k so k loses to all others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q <= '1;
    end else if (upd) begin
      for (int i = 0; i < N; i++) begin
        for (int j = i + 1; j < N; j++) begin
          if (upd_onehot[i]) begin
            p_q[tri_idx(N, i, j)] <= 1'b0;
          end else if (upd_onehot[j]) begin
            p_q[tri_idx(N, i, j)] <= 1'b1;
          end
        end
      end
    end
  end

  // Winner: requesting i that beats every other requesting j; the lower
  // triangle is the complement of the stored upper triangle.
  always_comb begin
    logic beats;
    beats  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      winner[i] = req[i];
      for (int j = 0; j < N; j++) begin
        if (j != i) begin
          if (i < j) beats = p_q[tri_idx(N, i, j)];
          else       beats = ~p_q[tri_idx(N, j, i)];
          if (req[j] && !beats) winner[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/lru_matrix_arbiter.sv
// Least-recently-granted matrix arbiter with tenure hold.
// A grant is held until the owner drops req or signals last; the next
// winner is granted on the same edge with no idle gap.
// Optional feature: define LRU_ARB_HOLD_TIMEOUT_EN to bound every tenure
// to MAX_HOLD cycles; otherwise tenure is unbounded and MAX_HOLD is unused.
module lru_matrix_arbiter
  import lru_arb_pkg::*;
#(
  parameter int NUM_REQUESTORS = 4,
  parameter int MAX_HOLD       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lru_matrix_arbiter_if.slave  bus
);

  localparam int N    = NUM_REQUESTORS;
  localparam int ID_W = $clog2(N);

  if (N < 2 || N > 16 || MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_params
    $error("lru_matrix_arbiter: NUM_REQUESTORS or MAX_HOLD out of range");
  end

  arb_state_t      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic            grant_valid_q;
  logic            ready_q;
  logic [N-1:0]    winner;
  logic            upd;
  logic            any_req, held_req, held_last, timeout, release_now, arbitrate;

  assign any_req     = |bus.req;
  assign held_req    = |(bus.req & grant_q);
  assign held_last   = |(bus.last & grant_q);
  assign release_now = (state_q == HOLD) && (!held_req || held_last || timeout);
  // ready_q keeps the first edge after reset release grant-free.
  assign arbitrate   = ready_q && ((state_q == IDLE) || release_now);

  lru_matrix_prio #(.N(N)) u_prio (
    .clk        (clk),
    .rst        (rst),
    .req        (bus.req),
    .upd        (upd),
    .upd_onehot (winner),
    .winner     (winner)
  );

`ifdef LRU_ARB_HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CNT_W'(MAX_HOLD));

  // Tenure counter next state: 1 on a new grant, +1 per held cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (arbitrate)              cnt_d = any_req ? CNT_W'(1) : '0;
    else if (state_q == HOLD)   cnt_d = cnt_q + CNT_W'(1);
  end

  // Tenure counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // FSM next state, next grant and matrix-update strobe.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    upd     = 1'b0;
    if (arbitrate) begin
      if (any_req) begin
        grant_d = winner;
        state_d = HOLD;
        upd     = 1'b1;
      end else begin
        grant_d = '0;
        state_d = IDLE;
      end
    end
  end

  // One-hot to binary encoder for the next grant (0 when no grant).
  always_comb begin
    grant_id_d = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_d[i]) grant_id_d = ID_W'(i);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= |grant_d;
      ready_q       <= 1'b1;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid_q;

endmodule

// File: tb/tb_lru_matrix_arbiter.sv
// Self-checking bench for lru_matrix_arbiter (N=4, MAX_HOLD=4).
// Expected grants are pushed to a scoreboard queue as stimulus is driven
// and popped after the following rising edge for comparison.
module tb_lru_matrix_arbiter;

  logic clk;
  logic rst;

  lru_matrix_arbiter_if #(.NUM_REQUESTORS(4)) bus ();

  lru_matrix_arbiter #(.NUM_REQUESTORS(4), .MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_g;

`ifdef LRU_ARB_HOLD_TIMEOUT_EN
  localparam int HOLD_CYC = 2;
`else
  localparam int HOLD_CYC = 10;
`endif

  function automatic logic [1:0] oh2id(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    bus.req  = '0;
    bus.last = '0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [3:0] rq [4] = '{4'b0000, 4'b1111, 4'b1111, 4'b1111};
    logic [3:0] ex [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
    rst      = 1'b0;
    bus.req  = '0;
    bus.last = '0;
    #2;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        #3;
        rst = 1'b1;
      end
      bus.req = rq[k];
      sb_q.push_back(ex[k]);
      if (k > 0) tick();
      exp_g = sb_q.pop_front();
      n_checks++;
      if (bus.grant !== exp_g) begin
        n_fail++;
        $display("FAIL reset_grant step %0d: got %b expected %b", k, bus.grant, exp_g);
      end
      n_checks++;
      if (bus.grant_valid !== (|exp_g)) begin
        n_fail++;
        $display("FAIL reset_valid step %0d: got %b expected %b", k, bus.grant_valid, |exp_g);
      end
      n_checks++;
      if (bus.grant_id !== oh2id(exp_g)) begin
        n_fail++;
        $display("FAIL reset_id step %0d: got %0d expected %0d", k, bus.grant_id, oh2id(exp_g));
      end
      $display("reset step %0d: req=%b grant=%b", k, bus.req, bus.grant);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ex [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.req  = 4'b1111;
      bus.last = 4'b1111;
      sb_q.push_back(ex[k]);
      tick();
      exp_g = sb_q.pop_front();
      n_checks++;
      if (bus.grant !== exp_g) begin
        n_fail++;
        $display("FAIL rr_grant step %0d: got %b expected %b", k, bus.grant, exp_g);
      end
      n_checks++;
      if (bus.grant_id !== oh2id(exp_g) || bus.grant_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_id step %0d: got id %0d valid %b expected id %0d valid 1", k, bus.grant_id, bus.grant_valid, oh2id(exp_g));
      end
      $display("round_robin step %0d: grant=%b id=%0d", k, bus.grant, bus.grant_id);
    end
  endtask

  task automatic test_lru_update();
    logic [3:0] rq [3] = '{4'b0001, 4'b0101, 4'b0101};
    logic [3:0] ls [3] = '{4'b0000, 4'b0001, 4'b0100};
    logic [3:0] ex [3] = '{4'b0001, 4'b0100, 4'b0001};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.req  = rq[k];
      bus.last = ls[k];
      sb_q.push_back(ex[k]);
      tick();
      exp_g = sb_q.pop_front();
      n_checks++;
      if (bus.grant !== exp_g) begin
        n_fail++;
        $display("FAIL lru_grant step %0d: got %b expected %b", k, bus.grant, exp_g);
      end
      n_checks++;
      if (bus.grant_id !== oh2id(exp_g)) begin
        n_fail++;
        $display("FAIL lru_id step %0d: got %0d expected %0d", k, bus.grant_id, oh2id(exp_g));
      end
      $display("lru_update step %0d: req=%b last=%b grant=%b", k, rq[k], ls[k], bus.grant);
    end
  endtask

  task automatic test_hold();
    do_reset();
    for (int k = 0; k < HOLD_CYC + 2; k++) begin
      bus.req  = (k == 0) ? 4'b0010 : 4'b1010;
      bus.last = (k == HOLD_CYC + 1) ? 4'b0010 : 4'b0000;
      sb_q.push_back((k == HOLD_CYC + 1) ? 4'b1000 : 4'b0010);
      tick();
      exp_g = sb_q.pop_front();
      n_checks++;
      if (bus.grant !== exp_g) begin
        n_fail++;
        $display("FAIL hold_grant step %0d: got %b expected %b", k, bus.grant, exp_g);
      end
      $display("hold step %0d: req=%b last=%b grant=%b", k, bus.req, bus.last, bus.grant);
    end
  endtask

`ifdef LRU_ARB_HOLD_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 9; k++) begin
      bus.req  = 4'b1010;
      bus.last = 4'b0000;
      sb_q.push_back((k >= 4 && k < 8) ? 4'b1000 : 4'b0010);
      tick();
      exp_g = sb_q.pop_front();
      n_checks++;
      if (bus.grant !== exp_g) begin
        n_fail++;
        $display("FAIL timeout_grant step %0d: got %b expected %b", k, bus.grant, exp_g);
      end
      $display("timeout step %0d: grant=%b", k, bus.grant);
    end
  endtask
`endif

  task automatic test_drop();
    logic [3:0] rq [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic [3:0] ex [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.req  = rq[k];
      bus.last = 4'b0000;
      sb_q.push_back(ex[k]);
      tick();
      exp_g = sb_q.pop_front();
      n_checks++;
      if (bus.grant !== exp_g) begin
        n_fail++;
        $display("FAIL drop_grant step %0d: got %b expected %b", k, bus.grant, exp_g);
      end
      n_checks++;
      if (bus.grant_valid !== (|exp_g) || bus.grant_id !== oh2id(exp_g)) begin
        n_fail++;
        $display("FAIL drop_valid_id step %0d: got valid %b id %0d expected valid %b id %0d", k, bus.grant_valid, bus.grant_id, |exp_g, oh2id(exp_g));
      end
      $display("drop step %0d: req=%b grant=%b valid=%b id=%0d", k, rq[k], bus.grant, bus.grant_valid, bus.grant_id);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] ex [6] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    do_reset();
    for (int k = 0; k < 6; k++) begin
      sb_q.push_back(ex[k]);
      if (k == 2) begin
        #3;
        rst = 1'b0;
        #1;
      end else if (k == 4) begin
        #3;
        rst     = 1'b1;
        bus.req = 4'b1001;
        tick();
      end else begin
        bus.req = (k == 5) ? 4'b1001 : 4'b1000;
        tick();
      end
      exp_g = sb_q.pop_front();
      n_checks++;
      if (bus.grant !== exp_g) begin
        n_fail++;
        $display("FAIL areset_grant step %0d: got %b expected %b", k, bus.grant, exp_g);
      end
      n_checks++;
      if (bus.grant_valid !== (|exp_g) || bus.grant_id !== oh2id(exp_g)) begin
        n_fail++;
        $display("FAIL areset_valid_id step %0d: got valid %b id %0d expected valid %b id %0d", k, bus.grant_valid, bus.grant_id, |exp_g, oh2id(exp_g));
      end
      $display("async_reset step %0d: rst=%b req=%b grant=%b", k, rst, bus.req, bus.grant);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lru_update();
`ifdef LRU_ARB_HOLD_TIMEOUT_EN
    test_timeout();
`endif
    test_hold();
    test_drop();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
